// File: rtl/uart_frame_decoder.sv
// -----------------------------------------------------------------------------
// uart_frame_decoder
//
// Pops bytes from a UART RX FIFO and assembles fixed-format command frames:
//   SOF, CMD, ADDR, DATA_BYTES payload bytes (little-endian), CHK
// CHK is the XOR of CMD, ADDR and every payload byte. Good frames are offered
// on a valid/ready command bus. Bad frames (checksum mismatch, inter-byte
// timeout, receiver framing error) are dropped.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   rx_empty_i     RX FIFO empty flag
//   rx_re_o        RX FIFO read enable, single-cycle pulse
//   rx_data_i      RX FIFO read data, valid the cycle after rx_re_o
//   frame_error_i  receiver framing-error pulse, aborts a frame in progress
//   cmd_valid_o    decoded command available
//   cmd_ready_i    downstream accepts the command
//   cmd_o          command byte
//   addr_o         address byte
//   data_o         payload, first received byte in bits [7:0]
//   chk_err_o      one-cycle pulse on checksum mismatch
//   timeout_err_o  one-cycle pulse on inter-byte timeout
//   busy_o         high whenever a frame is being assembled or presented
// -----------------------------------------------------------------------------
module uart_frame_decoder #(
   parameter int unsigned DATA_BYTES     = 2,
   parameter logic [7:0]  SOF_BYTE       = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    rx_empty_i,
   output logic                    rx_re_o,
   input  logic [7:0]              rx_data_i,
   input  logic                    frame_error_i,
   output logic                    cmd_valid_o,
   input  logic                    cmd_ready_i,
   output logic [7:0]              cmd_o,
   output logic [7:0]              addr_o,
   output logic [8*DATA_BYTES-1:0] data_o,
   output logic                    chk_err_o,
   output logic                    timeout_err_o,
   output logic                    busy_o
);

   localparam int unsigned     IDX_W    = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BYTES - 1);
   localparam logic [31:0]     TO_LAST  = 32'(TIMEOUT_CYCLES - 1);
   localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);

   typedef enum logic [2:0] {HUNT, CMD, ADDR, DATA, CHK, OUT} state_e;

   state_e                  state_q, state_d;
   logic                    pop_pending_q;
   logic                    drop_q;        // byte of an aborted frame still in flight
   logic [31:0]             to_cnt_q;
   logic [IDX_W-1:0]        idx_q;
   logic [7:0]              chk_acc_q;
   logic [7:0]              cmd_q;
   logic [7:0]              addr_q;
   logic [8*DATA_BYTES-1:0] data_q;
   logic                    chk_err_d;
   logic                    to_err_d;

   logic in_frame;
   logic byte_cycle;
   logic abort;
   logic to_hit;

   assign in_frame   = (state_q == CMD) || (state_q == ADDR) ||
                       (state_q == DATA) || (state_q == CHK);
   assign byte_cycle = pop_pending_q;
   assign abort      = in_frame && frame_error_i;
   // A byte arriving on the terminal count wins over the timeout.
   assign to_hit     = TO_EN && in_frame && !byte_cycle && (to_cnt_q == TO_LAST);

   // Gated by rst_ni so the FIFO is never popped while the block is held in
   // reset, even though the state register already reads HUNT.
   assign rx_re_o     = rst_ni && (state_q != OUT) && !rx_empty_i && !pop_pending_q;
   assign cmd_valid_o = (state_q == OUT);
   assign busy_o      = (state_q != HUNT);

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      chk_err_d = 1'b0;
      to_err_d  = 1'b0;
      case (state_q)
         HUNT: if (byte_cycle && !drop_q && rx_data_i == SOF_BYTE) state_d = CMD;
         CMD:  if (byte_cycle) state_d = ADDR;
         ADDR: if (byte_cycle) state_d = DATA;
         DATA: if (byte_cycle && idx_q == IDX_LAST) state_d = CHK;
         CHK: begin
            if (byte_cycle) begin
               if (rx_data_i == chk_acc_q) begin
                  state_d = OUT;
               end else begin
                  state_d   = HUNT;
                  chk_err_d = 1'b1;
               end
            end
         end
         OUT:     if (cmd_ready_i) state_d = HUNT;
         default: state_d = HUNT;
      endcase
      // Aborts are silent: the receiver has already flagged the error.
      if (abort) begin
         state_d   = HUNT;
         chk_err_d = 1'b0;
      end else if (to_hit) begin
         state_d  = HUNT;
         to_err_d = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= HUNT;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pop_pending_q <= 1'b0;
         drop_q        <= 1'b0;
         to_cnt_q      <= '0;
         idx_q         <= '0;
         chk_acc_q     <= '0;
         cmd_q         <= '0;
         addr_q        <= '0;
         data_q        <= '0;
         cmd_o         <= '0;
         addr_o        <= '0;
         data_o        <= '0;
         chk_err_o     <= 1'b0;
         timeout_err_o <= 1'b0;
      end else begin
         pop_pending_q <= rx_re_o;
         chk_err_o     <= chk_err_d;
         timeout_err_o <= to_err_d;

         // A pop issued in the abort cycle returns its byte in HUNT; mark it
         // so it cannot be mistaken for the start of a new frame.
         if (byte_cycle)            drop_q <= 1'b0;
         else if (abort && rx_re_o) drop_q <= 1'b1;

         // Entering CMD is always a byte cycle, so this also clears on entry.
         if (in_frame && !byte_cycle) to_cnt_q <= to_cnt_q + 32'd1;
         else                         to_cnt_q <= '0;

         // Fields assemble in shadow registers so the bus outputs keep the
         // last good command until the next frame passes its checksum.
         if (byte_cycle && !abort) begin
            case (state_q)
               CMD: begin
                  cmd_q     <= rx_data_i;
                  chk_acc_q <= rx_data_i;
               end
               ADDR: begin
                  addr_q    <= rx_data_i;
                  chk_acc_q <= chk_acc_q ^ rx_data_i;
                  idx_q     <= '0;
               end
               DATA: begin
                  data_q[8*idx_q +: 8] <= rx_data_i;
                  chk_acc_q            <= chk_acc_q ^ rx_data_i;
                  idx_q                <= idx_q + 1'b1;
               end
               default: ;
            endcase
         end

         if (state_q == CHK && state_d == OUT) begin
            cmd_o  <= cmd_q;
            addr_o <= addr_q;
            data_o <= data_q;
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_decoder
//
// Self-checking bench for uart_frame_decoder (DATA_BYTES=2, TIMEOUT_CYCLES=20).
// An RX FIFO model feeds bytes; a negedge monitor records handshakes, error
// pulses and pops. Directed vectors come from a table, corner cases from
// hand-written sequences, and random byte streams are checked against a
// frame-scanning reference model.
// -----------------------------------------------------------------------------
module tb_uart_frame_decoder;

   localparam int         DB  = 2;
   localparam int         TO  = 20;
   localparam logic [7:0] SOF = 8'hA5;

   logic          clk = 1'b0;
   logic          rst_ni;
   logic          rx_empty_i;
   logic          rx_re_o;
   logic [7:0]    rx_data_i;
   logic          frame_error_i;
   logic          cmd_valid_o;
   logic          cmd_ready_i;
   logic [7:0]    cmd_o;
   logic [7:0]    addr_o;
   logic [8*DB-1:0] data_o;
   logic          chk_err_o;
   logic          timeout_err_o;
   logic          busy_o;

   uart_frame_decoder #(
      .DATA_BYTES(DB), .SOF_BYTE(SOF), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni), .rx_empty_i(rx_empty_i), .rx_re_o(rx_re_o),
      .rx_data_i(rx_data_i), .frame_error_i(frame_error_i),
      .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_o(cmd_o),
      .addr_o(addr_o), .data_o(data_o), .chk_err_o(chk_err_o),
      .timeout_err_o(timeout_err_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // ---------------- monitor state ----------------
   int          cyc = 0;
   int          pops, pop_cyc, to_cyc;
   int          n_chk, n_to, n_overlap, n_pop_in_out;
   bit          re_seen = 1'b0;
   logic [31:0] obs[$];      // {cmd, addr, data} per accepted command
   logic [7:0]  fifo[$];

   // ---------------- reference model results ----------------
   logic [31:0] exp_q[$];
   int          exp_chk, exp_to;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Outputs are sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      cyc++;
      re_seen = rx_re_o;
      if (rx_re_o) begin
         pops++;
         pop_cyc = cyc;
      end
      if (cmd_valid_o && cmd_ready_i) obs.push_back({cmd_o, addr_o, data_o});
      if (chk_err_o) n_chk++;
      if (timeout_err_o) begin
         n_to++;
         to_cyc = cyc;
      end
      if (chk_err_o && timeout_err_o) n_overlap++;
      if (cmd_valid_o && rx_re_o) n_pop_in_out++;
   end

   // RX FIFO model: a pop seen in one cycle presents its byte in the next.
   always @(posedge clk) begin
      #1;
      if (re_seen && fifo.size() > 0) rx_data_i = fifo.pop_front();
      rx_empty_i = (fifo.size() == 0);
   end

   task automatic clear_mon();
      obs.delete();
      pops = 0; n_chk = 0; n_to = 0; n_overlap = 0; n_pop_in_out = 0;
   endtask

   task automatic run_until_idle(input string name, input int budget, input bit rnd);
      int n = 0;
      while ((fifo.size() != 0 || busy_o) && n < budget) begin
         @(posedge clk); #2;
         if (rnd) cmd_ready_i = 1'($urandom_range(0, 1));
         n++;
      end
      cmd_ready_i = 1'b1;
      if (n >= budget) begin
         errors++;
         checks++;
         $display("FAIL %s_idle: still busy after %0d cycles", name, n);
      end
      repeat (40) begin @(posedge clk); #2; end
   endtask

   // Scans a byte stream the way the frame format defines it: hunt for SOF,
   // take the fixed-length frame, compare the XOR. A frame cut short by the
   // end of the stream ends in a timeout.
   task automatic model_parse(input logic [7:0] s[$]);
      int          i = 0;
      logic [7:0]  x;
      logic [15:0] d;
      exp_q.delete();
      exp_chk = 0;
      exp_to  = 0;
      while (i < s.size()) begin
         if (s[i] != SOF) begin
            i++;
            continue;
         end
         if (s.size() - i < DB + 4) begin
            exp_to++;
            break;
         end
         x = '0;
         d = '0;
         for (int k = 1; k <= DB + 2; k++) x ^= s[i+k];
         for (int k = 0; k < DB; k++) d |= 16'(s[i+3+k]) << (8*k);
         if (x == s[i+DB+3]) exp_q.push_back({s[i+1], s[i+2], d});
         else                exp_chk++;
         i += DB + 4;
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [0:11][7:0] b;
      int               len;
      int               n_cmd;
      logic [31:0]      last;   // {cmd_o, addr_o, data_o} expected at the end
      int               n_chk;
      int               n_to;
   } vec_t;

   vec_t vecs[8];

   function automatic logic [0:11][7:0] mk(input int n, input logic [95:0] v);
      return v << (8*(12-n));
   endfunction

   task automatic push_frame(input logic [7:0] c, input logic [7:0] a,
                             input logic [7:0] d0, input logic [7:0] d1);
      fifo.push_back(SOF); fifo.push_back(c); fifo.push_back(a);
      fifo.push_back(d0);  fifo.push_back(d1); fifo.push_back(c ^ a ^ d0 ^ d1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] s[$];
      int         n, mism, byte_cyc, n_re, n_bad;

      rst_ni = 1'b0; rx_empty_i = 1'b1; rx_data_i = '0;
      frame_error_i = 1'b0; cmd_ready_i = 1'b1;
      clear_mon();

      vecs[0] = '{mk(6,  48'hA5_01_10_34_12_37), 6, 1, 32'h0110_1234, 0, 0};
      vecs[1] = '{mk(8,  64'h00_FF_A5_01_10_34_12_37), 8, 1, 32'h0110_1234, 0, 0};
      vecs[2] = '{mk(6,  48'hA5_01_10_34_12_36), 6, 0, 32'h0110_1234, 1, 0};
      vecs[3] = '{mk(12, 96'hA5_01_10_34_12_36_A5_02_20_CD_AB_44), 12, 1, 32'h0220_ABCD, 1, 0};
      vecs[4] = '{mk(6,  48'hA5_A5_A5_A5_A5_00), 6, 1, 32'hA5A5_A5A5, 0, 0};
      vecs[5] = '{mk(12, 96'hA5_03_04_00_FF_F8_A5_7E_81_5A_5A_FF), 12, 2, 32'h7E81_5A5A, 0, 0};
      vecs[6] = '{mk(3,  24'hA5_01_10), 3, 0, 32'h7E81_5A5A, 0, 1};
      vecs[7] = '{mk(3,  24'h12_34_56), 3, 0, 32'h7E81_5A5A, 0, 0};

      // ---- reset state ----
      repeat (3) @(posedge clk);
      #2;
      check("reset_flags", {cmd_valid_o, busy_o, chk_err_o, timeout_err_o, rx_re_o}, '0);
      check("reset_fields", {cmd_o, addr_o, data_o}, '0);
      rst_ni = 1'b1;
      repeat (2) @(posedge clk);
      #2;

      // ---- table-driven vectors ----
      for (int i = 0; i < 8; i++) begin
         clear_mon();
         for (int j = 0; j < vecs[i].len; j++) fifo.push_back(vecs[i].b[j]);
         run_until_idle($sformatf("vec%0d", i), 400, 1'b0);
         check($sformatf("vec%0d_ncmd", i), obs.size(), vecs[i].n_cmd);
         if (obs.size() > 0) check($sformatf("vec%0d_last_cmd", i), obs[obs.size()-1], vecs[i].last);
         check($sformatf("vec%0d_fields", i), {cmd_o, addr_o, data_o}, vecs[i].last);
         check($sformatf("vec%0d_chk_err", i), n_chk, vecs[i].n_chk);
         check($sformatf("vec%0d_to_err", i), n_to, vecs[i].n_to);
         check($sformatf("vec%0d_pops", i), pops, vecs[i].len);
         check($sformatf("vec%0d_busy", i), busy_o, 1'b0);
         check($sformatf("vec%0d_overlap", i), n_overlap, 0);
      end

      // ---- timeout: pulse after TO idle cycles following the CMD byte ----
      clear_mon();
      fifo.push_back(SOF); fifo.push_back(8'h01);
      n = 0;
      do begin @(negedge clk); #1; n++; end while (pops < 2 && n < 50);
      check("to_pops", pops, 2);
      byte_cyc = pop_cyc + 1;
      n = 0;
      do begin @(negedge clk); #1; n++; end while (!timeout_err_o && n < 100);
      check("to_seen", timeout_err_o, 1'b1);
      check("to_latency", cyc - byte_cyc, TO + 1);
      check("to_busy", busy_o, 1'b0);
      @(negedge clk); #1;
      check("to_width", timeout_err_o, 1'b0);
      check("to_no_cmd", obs.size(), 0);
      check("to_no_chk", n_chk, 0);

      // ---- backpressure ----
      clear_mon();
      @(posedge clk); #2;
      cmd_ready_i = 1'b0;
      push_frame(8'h01, 8'h10, 8'h34, 8'h12);
      push_frame(8'h02, 8'h20, 8'hCD, 8'hAB);
      n = 0;
      do begin @(negedge clk); #1; n++; end while (!cmd_valid_o && n < 100);
      check("bp_valid", cmd_valid_o, 1'b1);
      n_bad = 0;
      n_re  = 0;
      for (int k = 0; k < 100; k++) begin
         if (!cmd_valid_o || {cmd_o, addr_o, data_o} != 32'h0110_1234) n_bad++;
         if (rx_re_o) n_re++;
         @(negedge clk); #1;
      end
      check("bp_held", n_bad, 0);
      check("bp_no_pop", n_re, 0);
      check("bp_pops", pops, 6);
      @(posedge clk); #2;
      cmd_ready_i = 1'b1;
      run_until_idle("bp", 400, 1'b0);
      check("bp_ncmd", obs.size(), 2);
      if (obs.size() == 2) begin
         check("bp_cmd0", obs[0], 32'h0110_1234);
         check("bp_cmd1", obs[1], 32'h0220_ABCD);
      end

      // ---- abort with a pop in flight: the returning SOF must be dropped ----
      clear_mon();
      foreach (s[k]) s.delete();
      s = '{8'hA5, 8'h01, 8'hA5, 8'h02, 8'h03, 8'h04, 8'h05, 8'h04};
      foreach (s[k]) fifo.push_back(s[k]);
      n = 0;
      do begin @(negedge clk); #1; n++; end while (pops < 3 && n < 50);
      check("abort_pops", pops, 3);
      frame_error_i = 1'b1;
      @(negedge clk); #1;
      frame_error_i = 1'b0;
      check("abort_busy", busy_o, 1'b0);
      run_until_idle("abort", 400, 1'b0);
      check("abort_ncmd", obs.size(), 0);
      check("abort_errs", n_chk + n_to, 0);
      clear_mon();
      push_frame(8'h02, 8'h20, 8'hCD, 8'hAB);
      run_until_idle("abort_next", 400, 1'b0);
      check("abort_next_ncmd", obs.size(), 1);
      check("abort_next_fields", {cmd_o, addr_o, data_o}, 32'h0220_ABCD);

      // ---- reset in the middle of DATA ----
      clear_mon();
      push_frame(8'h01, 8'h10, 8'h34, 8'h12);
      n = 0;
      do begin @(negedge clk); #1; n++; end while (pops < 4 && n < 50);
      check("rst_pops", pops, 4);
      rst_ni = 1'b0;
      #1;
      check("rst_flags", {cmd_valid_o, busy_o, chk_err_o, timeout_err_o, rx_re_o}, '0);
      check("rst_fields", {cmd_o, addr_o, data_o}, '0);
      fifo.delete();
      repeat (2) @(posedge clk);
      #2;
      rst_ni = 1'b1;
      clear_mon();
      push_frame(8'h01, 8'h10, 8'h34, 8'h12);
      run_until_idle("rst_next", 400, 1'b0);
      check("rst_next_ncmd", obs.size(), 1);
      check("rst_next_fields", {cmd_o, addr_o, data_o}, 32'h0110_1234);
      check("rst_next_pops", pops, 6);

      // ---- randomized streams against the reference model ----
      for (int t = 0; t < 20; t++) begin
         logic [7:0] c, a, d0, d1, x;
         s.delete();
         while (s.size() < 30) begin
            n = int'($urandom_range(0, 9));
            if (n <= 7) begin
               c = 8'($urandom); a = 8'($urandom); d0 = 8'($urandom); d1 = 8'($urandom);
               x = c ^ a ^ d0 ^ d1;
               if (n >= 6) x ^= 8'($urandom_range(1, 255));
               s.push_back(SOF); s.push_back(c); s.push_back(a);
               s.push_back(d0);  s.push_back(d1); s.push_back(x);
            end else begin
               s.push_back(8'($urandom));
            end
         end
         model_parse(s);
         clear_mon();
         foreach (s[k]) fifo.push_back(s[k]);
         run_until_idle($sformatf("rand%0d", t), 3000, 1'b1);
         mism = 0;
         for (int k = 0; k < obs.size() && k < exp_q.size(); k++)
            if (obs[k] != exp_q[k]) mism++;
         check($sformatf("rand%0d_ncmd", t), obs.size(), exp_q.size());
         check($sformatf("rand%0d_cmds", t), mism, 0);
         check($sformatf("rand%0d_chk_err", t), n_chk, exp_chk);
         check($sformatf("rand%0d_to_err", t), n_to, exp_to);
         check($sformatf("rand%0d_hygiene", t), n_overlap + n_pop_in_out, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
